bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Parallel-to-serial front end for the serial pattern detector.
//  Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per Clk on SerOut.
//  SerOut drives the detector's serial input directly.
//  A one-word holding register lets consecutive words stream with no idle gap between them.
// PARAMETERS
//  WIDTH      8   bits per word, >= 2
//  MSB_FIRST  1   1: DataIn[WIDTH-1] is sent first; 0: DataIn[0] is sent first
//  IDLE_BIT   0   value driven on SerOut whenever no word is being shifted
// PORTS
//  Clk        in   1      clock, all state updates on posedge
//  Rst        in   1      synchronous reset, active-high
//  DataIn     in   WIDTH  parallel word, sampled when DataValid && DataReady
//  DataValid  in   1      upstream word available
//  DataReady  out  1      block can take a word this cycle
//  SerOut     out  1      serial bit, registered
//  SerValid   out  1      1 while SerOut carries a data bit
//  WordDone   out  1      1 during the cycle carrying the last bit of a word
//  Busy       out  1      shifter active or holding register occupied
// BEHAVIOUR
//  Reset (Rst=1 at posedge, overrides all other inputs):
//   - state=IDLE; holding register empty; bit counter=0.
//   - SerOut=IDLE_BIT, SerValid=0, WordDone=0, Busy=0, DataReady=1.
//   - Any word in flight or held is discarded.
//  Handshake:
//   - DataReady = !hold_full, combinational from registered state only, never from DataValid.
//   - A word is accepted on a posedge where DataValid && DataReady. DataIn must be stable only at that edge.
//  States: IDLE, SHIFT; bit counter cnt runs 0..WIDTH-1 ($clog2(WIDTH) bits).
//   - IDLE, accept        -> SHIFT: load the shifter with DataIn, cnt=0.
//   - SHIFT, cnt<WIDTH-1  -> SHIFT: advance the shifter, cnt+1.
//   - SHIFT, cnt==WIDTH-1 (last bit):
//       - hold_full: move the held word to the shifter, hold empties, cnt=0, stay in SHIFT.
//       - else, accept this edge: load DataIn straight into the shifter, cnt=0, stay in SHIFT.
//       - else: go to IDLE.
//   - SHIFT, not last bit, accept: DataIn goes to the holding register, hold_full=1.
//   - Priority: the held word always shifts before any new word. DataReady=0 while hold_full, so a held word and a new word never collide.
//  Latency and ordering:
//   - Word accepted at edge k: its first bit is on SerOut in the cycle after edge k.
//   - Bit i of the word appears at cycle k+1+i.
//   - SerValid=1 for exactly WIDTH cycles per word.
//  WordDone=1 exactly when SerValid=1 and cnt==WIDTH-1.
//  Back-to-back streaming: the first bit of the next word follows the last bit of the previous word with no gap.
//  Outputs when idle: SerOut=IDLE_BIT, SerValid=0.
//  Busy = (state==SHIFT) || hold_full.
//  Rst asserted mid-word: the next cycle shows the reset values above, and no further bits from that word appear.
// TESTING
//  1. Reset: Rst high 2 cycles with DataValid=1 -> no word accepted; SerOut=0, SerValid=0, DataReady=1, Busy=0.
//  2. Single word: WIDTH=8, MSB_FIRST=1, accept 8'hA5 at edge k.
//     -> SerOut over cycles k+1..k+8 = 1,0,1,0,0,1,0,1; SerValid=1 for those cycles; WordDone only at k+8; idle at k+9.
//  3. Back-to-back: DataValid held high with 8'hA0 then 8'h05.
//     -> 16 contiguous valid bits 1010000000000101; DataReady drops while the holding register is full.
//     -> Feeding the stream to the detector gives exactly two Out pulses.
//  4. Backpressure: hold_full while DataValid=1 with 8'hFF -> no acceptance until the held word moves; no word lost or duplicated.
//  5. Reset mid-word: Rst at bit 3 of 8'hFF -> SerValid=0 and SerOut=IDLE_BIT the next cycle; held word discarded; a new word afterwards starts cleanly.
//  6. MSB_FIRST=0, WIDTH=4: accept 4'b0011 -> SerOut = 1,1,0,0.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and emits one bit per Clk.
// A one-word holding register lets consecutive words stream back-to-back with no idle gap.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             DataValid,
    output logic             DataReady,
    output logic             SerOut,
    output logic             SerValid,
    output logic             WordDone,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             accept, last_bit;
    logic [WIDTH-1:0] sh_adv;

    assign DataReady = !hold_full_q;
    assign accept    = DataValid && DataReady;
    assign last_bit  = (cnt_q == CW'(WIDTH-1));
    // The bit on SerOut always sits at the outgoing end of the shifter.
    assign sh_adv    = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sh_d    = DataIn;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sh_d  = sh_adv;
                    cnt_d = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d      = DataIn;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Held word always goes first; DataReady is low so nothing new can arrive.
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    sh_d  = DataIn;
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign SerValid = (state_q == SHIFT);
    assign SerOut   = SerValid ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
    assign WordDone = SerValid && last_bit;
    assign Busy     = SerValid || hold_full_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Randomized scoreboard bench for bit_serializer: a bit-queue model predicts the serial stream,
// handshake and status outputs; a second small instance covers LSB-first, WIDTH=4.
module tb_bit_serializer;
    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic [W-1:0] DataIn = '0;
    logic         DataValid = 1'b0;
    logic         DataReady, SerOut, SerValid, WordDone, Busy;

    logic [3:0]   d2_in = '0;
    logic         d2_valid = 1'b0;
    logic         d2_ready, d2_ser, d2_sval, d2_done, d2_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) u_dut (
        .Clk(Clk), .Rst(Rst), .DataIn(DataIn), .DataValid(DataValid), .DataReady(DataReady),
        .SerOut(SerOut), .SerValid(SerValid), .WordDone(WordDone), .Busy(Busy));

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .Clk(Clk), .Rst(Rst), .DataIn(d2_in), .DataValid(d2_valid), .DataReady(d2_ready),
        .SerOut(d2_ser), .SerValid(d2_sval), .WordDone(d2_done), .Busy(d2_busy));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted word contributes WIDTH {last,bit} entries, in transmit order.
    // Anything beyond the WIDTH-entry window in flight means the holding register is occupied.
    logic [1:0]   exp_q[$];
    logic         rst_pend = 1'b1;
    logic         acc_pend = 1'b0;
    logic [W-1:0] acc_word = '0;

    always @(negedge Clk) begin
        logic [1:0] e;
        if (rst_pend) exp_q.delete();
        else if (acc_pend)
            for (int i = 0; i < W; i++)
                exp_q.push_back({i == W-1, acc_word[W-1-i]});
        chk("DataReady", 32'(DataReady), 32'(exp_q.size() <= W));
        chk("Busy",      32'(Busy),      32'(exp_q.size() > 0));
        chk("SerValid",  32'(SerValid),  32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("SerOut",   32'(SerOut),   32'(e[0]));
            chk("WordDone", 32'(WordDone), 32'(e[1]));
        end else begin
            chk("SerOut_idle",   32'(SerOut),   32'(IDLE));
            chk("WordDone_idle", 32'(WordDone), 32'(0));
        end
        rst_pend = Rst;
        acc_pend = DataValid && DataReady && !Rst;
        acc_word = DataIn;
    end

    task automatic send(input logic [W-1:0] w);
        bit done = 0;
        DataIn = w;
        DataValid = 1'b1;
        for (int c = 0; c < 3*W+5 && !done; c++) begin
            @(negedge Clk);
            if (DataReady) begin
                @(posedge Clk);
                #1;
                done = 1;
            end
        end
        DataValid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: word %0h never accepted", w);
        end
    endtask

    task automatic idle(input int n);
        DataValid = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_rst();
        DataValid = 1'b0;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp2;
        DataValid = 1'b1;
        DataIn = W'($urandom);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        DataValid = 1'b0;

        send(8'hA5);
        idle(10);
        send(8'hA0);
        send(8'h05);
        idle(20);
        send(W'($urandom));
        send(W'($urandom));
        send(8'hFF);
        idle(25);

        // Reset lands mid-word while a second word is held.
        send(8'hFF);
        send(8'h3C);
        idle(2);
        pulse_rst();
        idle(3);
        send(8'h81);
        idle(12);

        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 14) send(W'($urandom));
            else if (r < 19) idle(int'($urandom_range(0, 3)));
            else pulse_rst();
        end
        idle(30);

        // LSB-first, 4-bit instance.
        exp2 = 4'b0011;
        d2_in = exp2;
        d2_valid = 1'b1;
        @(negedge Clk);
        chk("lsb_ready", 32'(d2_ready), 32'(1));
        @(posedge Clk);
        #1;
        d2_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("lsb_SerOut",   32'(d2_ser),  32'(exp2[i]));
            chk("lsb_SerValid", 32'(d2_sval), 32'(1));
            chk("lsb_WordDone", 32'(d2_done), 32'(i == 3));
        end
        @(negedge Clk);
        chk("lsb_idle_valid", 32'(d2_sval), 32'(0));
        chk("lsb_idle_busy",  32'(d2_busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
